// File: rtl/dco_id_counter.sv
`default_nettype none
// ============================================================================
//  Module   : dco_id_counter
//  Purpose  : DPLL increment/decrement counter stage. Inserts or deletes pulses
//             in a nominal clk/2 stream from loop-filter carry/borrow requests,
//             then divides the stream by a programmable N to recover the clock.
//  Revision : 1.0 - initial release
// ============================================================================
module dco_id_counter #(
    parameter int N_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               carry,
    input  logic               borrow,
    input  logic [N_WIDTH-1:0] nDiv,
    output logic               idOut,
    output logic               fOut,
    output logic               wrapPulse,
    output logic [3:0]         pendCount,
    output logic               satFlag
);

    localparam logic [3:0]         c_PEND_MAX = 4'b0111;
    localparam logic [3:0]         c_PEND_MIN = 4'b1001;
    localparam logic [N_WIDTH-1:0] c_DIV_MIN  = N_WIDTH'(2);

    // Slot phase, pending correction and divider state
    logic               ph_q,        ph_d;
    logic [3:0]         pend_q,      pend_d;
    logic [N_WIDTH-1:0] div_count_q, div_count_d;
    logic [N_WIDTH-1:0] div_latch_q, div_latch_d;

    // Registered outputs
    logic               id_out_q,    id_out_d;
    logic               f_out_q,     f_out_d;
    logic               wrap_q,      wrap_d;
    logic               sat_q,       sat_d;

    // Combinational decision terms
    logic               w_pend_neg;
    logic               w_pend_pos;
    logic               w_pulse;
    logic signed [4:0]  w_cons;
    logic signed [4:0]  w_sum;
    logic               w_sat_hi;
    logic               w_sat_lo;
    logic               w_last;
    logic [N_WIDTH-1:0] w_count_nxt;
    logic [N_WIDTH-1:0] w_eff_ndiv;
    logic [N_WIDTH:0]   w_half_latch;

    assign w_pend_neg = pend_q[3];
    assign w_pend_pos = ~pend_q[3] & (|pend_q[2:0]);

    // Scheduled slots are dropped while corrections are owed negative;
    // idle slots are filled while corrections are owed positive.
    always_comb begin
        w_pulse = 1'b0;
        w_cons  = 5'sd0;
        if (ph_q) begin
            if (w_pend_neg) begin
                w_cons = 5'sd1;
            end else begin
                w_pulse = 1'b1;
            end
        end else if (w_pend_pos) begin
            w_pulse = 1'b1;
            w_cons  = -5'sd1;
        end
    end

    assign w_sum    = $signed({pend_q[3], pend_q}) + w_cons
                    + $signed({4'b0000, carry}) - $signed({4'b0000, borrow});
    assign w_sat_hi = (w_sum > 5'sd7);
    assign w_sat_lo = (w_sum < -5'sd7);

    assign w_last       = (div_count_q == (div_latch_q - N_WIDTH'(1)));
    assign w_count_nxt  = w_last ? '0 : (div_count_q + N_WIDTH'(1));
    assign w_eff_ndiv   = (nDiv < c_DIV_MIN) ? c_DIV_MIN : nDiv;
    assign w_half_latch = ({1'b0, div_latch_q} + (N_WIDTH+1)'(1)) >> 1;

    always_comb begin
        ph_d        = ph_q;
        pend_d      = pend_q;
        div_count_d = div_count_q;
        div_latch_d = div_latch_q;
        id_out_d    = 1'b0;
        f_out_d     = f_out_q;
        wrap_d      = 1'b0;
        sat_d       = 1'b0;

        if (enable) begin
            ph_d     = ~ph_q;
            id_out_d = w_pulse;
            sat_d    = w_sat_hi | w_sat_lo;

            if (w_sat_hi) begin
                pend_d = c_PEND_MAX;
            end else if (w_sat_lo) begin
                pend_d = c_PEND_MIN;
            end else begin
                pend_d = w_sum[3:0];
            end

            // Duty decode uses the ratio of the period just completed.
            if (w_pulse) begin
                div_count_d = w_count_nxt;
                f_out_d     = ({1'b0, w_count_nxt} < w_half_latch);
                wrap_d      = w_last;
                if (w_last) begin
                    div_latch_d = w_eff_ndiv;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_q        <= 1'b0;
            pend_q      <= 4'b0000;
            div_count_q <= '0;
            div_latch_q <= c_DIV_MIN;
            id_out_q    <= 1'b0;
            f_out_q     <= 1'b0;
            wrap_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            pend_q      <= pend_d;
            div_count_q <= div_count_d;
            div_latch_q <= div_latch_d;
            id_out_q    <= id_out_d;
            f_out_q     <= f_out_d;
            wrap_q      <= wrap_d;
            sat_q       <= sat_d;
        end
    end

    assign idOut     = id_out_q;
    assign fOut      = f_out_q;
    assign wrapPulse = wrap_q;
    assign pendCount = pend_q;
    assign satFlag   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_dco_id_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dco_id_counter
//  Purpose  : Self-checking bench for dco_id_counter (scoreboard + directed).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dco_id_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       carry;
    logic       borrow;
    logic [7:0] nDiv;
    logic       idOut;
    logic       fOut;
    logic       wrapPulse;
    logic [3:0] pendCount;
    logic       satFlag;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    bit m_ph;
    int m_pend, m_cnt, m_lat;
    bit m_id, m_f, m_wrap, m_sat;

    int cnt_id, cnt_sat, min_pend;

    always #5 clk = ~clk;

    dco_id_counter #(.N_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .carry     (carry),
        .borrow    (borrow),
        .nDiv      (nDiv),
        .idOut     (idOut),
        .fOut      (fOut),
        .wrapPulse (wrapPulse),
        .pendCount (pendCount),
        .satFlag   (satFlag)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_pend = 0; m_cnt = 0; m_lat = 2;
        m_id = 0; m_f = 0; m_wrap = 0; m_sat = 0;
    endtask

    // Behavioural reference of one enabled/disabled clock edge
    task automatic model_step(input bit en, input bit c, input bit b, input int nd);
        int  cons;
        int  s;
        int  old_lat;
        bit  p;
        if (!en) begin
            m_id = 0; m_wrap = 0; m_sat = 0;
            return;
        end
        cons = 0;
        p    = 0;
        if (m_ph) begin
            if (m_pend < 0) cons = 1;
            else            p = 1;
        end else if (m_pend > 0) begin
            p = 1;
            cons = -1;
        end
        s      = m_pend + cons + int'(c) - int'(b);
        m_sat  = (s > 7) || (s < -7);
        m_pend = (s > 7) ? 7 : ((s < -7) ? -7 : s);
        m_id   = p;
        m_wrap = 0;
        if (p) begin
            old_lat = m_lat;
            if (m_cnt == m_lat - 1) begin
                m_cnt  = 0;
                m_lat  = (nd < 2) ? 2 : nd;
                m_wrap = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_f = (m_cnt < (old_lat + 1) / 2);
        end
        m_ph = !m_ph;
    endtask

    task automatic step(input bit en, input bit c, input bit b);
        logic [7:0] e;
        logic [31:0] pv;
        enable = en;
        carry  = c;
        borrow = b;
        @(posedge clk);
        model_step(en, c, b, int'(nDiv));
        pv = m_pend;
        e  = {m_id, m_f, m_wrap, pv[3:0], m_sat};
        exp_q.push_back(e);
        #1;
        cnt_id  += int'(idOut);
        cnt_sat += int'(satFlag);
        if (int'($signed(pendCount)) < min_pend) min_pend = int'($signed(pendCount));
    endtask

    // Monitor: pops one expected output vector per evaluated edge
    initial begin
        logic [7:0] e;
        logic [7:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {idOut, fOut, wrapPulse, pendCount, satFlag};
                chk("cycle_out{id,f,wrap,pend,sat}", int'(a), int'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fhi, wr, last_w, n, found, hi;

        reset = 1'b0; enable = 1'b0; carry = 1'b0; borrow = 1'b0; nDiv = 8'd4;
        model_reset();
        cnt_id = 0; cnt_sat = 0; min_pend = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", int'({idOut, fOut, wrapPulse, pendCount, satFlag}), 0);

        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Nominal cadence and first wrap at ratio 2
        step(1, 0, 0); chk("cadence_edge1", int'(idOut), 0);
        step(1, 0, 0); chk("cadence_edge2", int'(idOut), 1);
        step(1, 0, 0); chk("cadence_edge3", int'(idOut), 0);
        step(1, 0, 0); chk("first_wrap_edge4", int'(wrapPulse), 1);
        chk("first_wrap_fout", int'(fOut), 1);

        // Steady state, nDiv=4
        cnt_id = 0; fhi = 0; wr = 0; last_w = -1;
        for (int i = 0; i < 100; i++) begin
            step(1, 0, 0);
            if (i < 96) begin
                fhi += int'(fOut);
                wr  += int'(wrapPulse);
            end
            if (wrapPulse) begin
                if (last_w >= 0) chk("wrap_gap", i - last_w, 8);
                last_w = i;
            end
        end
        chk("nominal_id_count", cnt_id, 50);
        chk("nominal_fout_high", fhi, 48);
        chk("nominal_wrap_count", wr, 12);

        // Single carry
        cnt_id = 0;
        step(1, 1, 0);
        chk("carry_pend", int'(pendCount), 1);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("carry_pend_back", int'(pendCount), 0);
        for (int i = 0; i < 97; i++) step(1, 0, 0);
        chk("carry_id_count", cnt_id, 51);

        // Single borrow
        cnt_id = 0;
        step(1, 0, 1);
        chk("borrow_pend", int'(pendCount), 4'hF);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("borrow_pend_back", int'(pendCount), 0);
        for (int i = 0; i < 97; i++) step(1, 0, 0);
        chk("borrow_id_count", cnt_id, 49);

        // Carry and borrow together cancel
        cnt_id = 0; cnt_sat = 0; min_pend = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1);
            chk("both_pend", int'(pendCount), 0);
        end
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk("both_id_count", cnt_id, 5);
        chk("both_sat_count", cnt_sat, 0);

        // Enable low holds state and ignores carry
        cnt_id = 0;
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        chk("disable_pend_hold", int'(pendCount), 0);
        chk("disable_id_count", cnt_id, 0);

        // Borrow held for 20 cycles saturates at -7
        cnt_id = 0; cnt_sat = 0; min_pend = 0;
        for (int i = 0; i < 20; i++) step(1, 0, 1);
        chk("hold_min_pend", min_pend, -7);
        chk("hold_pend_end", int'(pendCount), 4'h9);
        chk("hold_sat_seen", int'(cnt_sat >= 1), 1);
        chk("hold_id_at_most_1", int'(cnt_id <= 1), 1);
        cnt_id = 0;
        for (int i = 0; i < 30; i++) step(1, 0, 0);
        chk("release_id_count", cnt_id, 8);
        chk("release_pend_back", int'(pendCount), 0);

        // nDiv 4 -> 5 mid-period
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step(1, 0, 0);
            if (wrapPulse) found = 1;
        end
        chk("wrap_found", found, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        nDiv = 8'd5;
        n = 2; found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step(1, 0, 0);
            n++;
            if (wrapPulse) found = 1;
        end
        chk("old_ratio_period", n, 8);
        hi = int'(fOut);
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 0);
            hi += int'(fOut);
        end
        chk("ndiv5_fout_high", hi, 6);
        step(1, 0, 0);
        chk("ndiv5_wrap", int'(wrapPulse), 1);

        // Build pend=+3, then asynchronous reset
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            step(1, 1, 0);
            if (pendCount == 4'd3) found = 1;
        end
        chk("pend3_reached", found, 1);
        enable = 1'b0; carry = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_outs", int'({idOut, fOut, wrapPulse, pendCount, satFlag}), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 24; i++) step(1, 0, 0);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
